// File: rtl/wb_pkg.sv
// Shared writeback-stage types: alucode encodings for loads/stores, default widths
// and the held-entry payload struct.
package wb_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int RIDX_W_DEF = 5;
   localparam int OPC_W_DEF  = 6;

   localparam logic [OPC_W_DEF-1:0] OPC_LB  = 6'h10;
   localparam logic [OPC_W_DEF-1:0] OPC_LH  = 6'h11;
   localparam logic [OPC_W_DEF-1:0] OPC_LW  = 6'h12;
   localparam logic [OPC_W_DEF-1:0] OPC_LBU = 6'h14;
   localparam logic [OPC_W_DEF-1:0] OPC_LHU = 6'h15;
   localparam logic [OPC_W_DEF-1:0] OPC_SB  = 6'h18;
   localparam logic [OPC_W_DEF-1:0] OPC_SH  = 6'h19;
   localparam logic [OPC_W_DEF-1:0] OPC_SW  = 6'h1A;

   typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_e;

   typedef struct packed {
      logic [XLEN_DEF-1:0]   pc_next;
      logic                  br_taken;
      logic                  reg_we;
      logic [RIDX_W_DEF-1:0] rd;
      logic [XLEN_DEF-1:0]   wdata;
   } wb_payload_t;

   function automatic acc_size_e access_size(input logic [OPC_W_DEF-1:0] opc);
      case (opc)
         OPC_LB, OPC_LBU, OPC_SB: return SZ_BYTE;
         OPC_LH, OPC_LHU, OPC_SH: return SZ_HALF;
         OPC_LW, OPC_SW:          return SZ_WORD;
         default:                 return SZ_NONE;
      endcase
   endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Bus bundle for wb_stage: upstream payload/handshake, downstream result/handshake,
// store path and decode bypass. master = surrounding pipeline, slave = wb_stage.
interface wb_stage_if
   import wb_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int RIDX_W = RIDX_W_DEF,
   parameter int OPC_W  = OPC_W_DEF
);
   logic              in_valid;
   logic              in_ready;
   logic [XLEN-1:0]   in_pc_next;
   logic              in_br_taken;
   logic              in_is_load;
   logic              in_is_store;
   logic              in_reg_we;
   logic [RIDX_W-1:0] in_rd;
   logic [OPC_W-1:0]  in_alucode;
   logic [XLEN-1:0]   in_alu_result;
   logic [XLEN-1:0]   in_rs2;
   logic [XLEN-1:0]   in_mem_rdata;
   logic              flush;

   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_pc_next;
   logic              out_br_taken;
   logic              out_reg_we;
   logic [RIDX_W-1:0] out_rd;
   logic [XLEN-1:0]   out_wdata;

   logic [XLEN-1:0]   st_data;
   logic [3:0]        st_be;
   logic              st_en;
   logic              misaligned;

   logic              fwd_valid;
   logic [RIDX_W-1:0] fwd_rd;
   logic [XLEN-1:0]   fwd_data;

   modport master (
      output in_valid, in_pc_next, in_br_taken, in_is_load, in_is_store, in_reg_we,
             in_rd, in_alucode, in_alu_result, in_rs2, in_mem_rdata, flush, out_ready,
      input  in_ready, out_valid, out_pc_next, out_br_taken, out_reg_we, out_rd,
             out_wdata, st_data, st_be, st_en, misaligned, fwd_valid, fwd_rd, fwd_data
   );

   modport slave (
      input  in_valid, in_pc_next, in_br_taken, in_is_load, in_is_store, in_reg_we,
             in_rd, in_alucode, in_alu_result, in_rs2, in_mem_rdata, flush, out_ready,
      output in_ready, out_valid, out_pc_next, out_br_taken, out_reg_we, out_rd,
             out_wdata, st_data, st_be, st_en, misaligned, fwd_valid, fwd_rd, fwd_data
   );
endinterface

// File: rtl/wb_stage_mem_align.sv
// mem_align: combinational byte/half lane extraction for loads, lane replication and
// byte enables for stores, and access alignment check.
module mem_align
   import wb_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int OPC_W = OPC_W_DEF
) (
   input  logic [OPC_W-1:0] alucode_i,
   input  logic             is_load_i,
   input  logic             is_store_i,
   input  logic [1:0]       addr_i,
   input  logic [XLEN-1:0]  rdata_i,
   input  logic [XLEN-1:0]  rs2_i,
   output logic [XLEN-1:0]  ld_data_o,
   output logic [XLEN-1:0]  st_data_o,
   output logic [3:0]       st_be_o,
   output logic             misaligned_o
);
   acc_size_e   sz;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign sz     = access_size(OPC_W_DEF'(alucode_i));
   assign byte_v = rdata_i[{addr_i, 3'b000} +: 8];
   assign half_v = rdata_i[{addr_i[1], 4'b0000} +: 16];

   always_comb begin
      ld_data_o = rdata_i;
      case (alucode_i)
         OPC_W'(OPC_LB):  ld_data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
         OPC_W'(OPC_LBU): ld_data_o = {{(XLEN-8){1'b0}}, byte_v};
         OPC_W'(OPC_LH):  ld_data_o = {{(XLEN-16){half_v[15]}}, half_v};
         OPC_W'(OPC_LHU): ld_data_o = {{(XLEN-16){1'b0}}, half_v};
         default:         ld_data_o = rdata_i;
      endcase
   end

   always_comb begin
      st_data_o = rs2_i;
      st_be_o   = 4'b0000;
      case (sz)
         SZ_BYTE: st_data_o = {(XLEN/8){rs2_i[7:0]}};
         SZ_HALF: st_data_o = {(XLEN/16){rs2_i[15:0]}};
         default: st_data_o = rs2_i;
      endcase
      if (is_store_i) begin
         case (sz)
            SZ_BYTE: st_be_o = 4'b0001 << addr_i;
            SZ_HALF: st_be_o = 4'b0011 << {addr_i[1], 1'b0};
            SZ_WORD: st_be_o = 4'b1111;
            default: st_be_o = 4'b0000;
         endcase
      end
   end

   assign misaligned_o = (is_load_i || is_store_i) &&
                         ((sz == SZ_HALF && addr_i[0]) || (sz == SZ_WORD && addr_i != 2'b00));

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback pipeline register with load formatting, store lane prep and
// decode bypass. Define WB_STAGE_SKID_EN for a one-entry skid buffer with registered in_ready.
module wb_stage
   import wb_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int RIDX_W = RIDX_W_DEF,
   parameter int OPC_W  = OPC_W_DEF
) (
   input logic       clk,
   input logic       rst,
   wb_stage_if.slave bus
);
   logic [XLEN-1:0] ld_data;
   logic            mis_raw;
   logic            misaligned;
   logic            in_ready;
   logic            cap;
   wb_payload_t     pl_new;
   wb_payload_t     out_q, out_d;
   logic            out_vld_q, out_vld_d;
`ifdef WB_STAGE_SKID_EN
   wb_payload_t     skid_q, skid_d;
   logic            skid_vld_q, skid_vld_d;
`endif

   mem_align #(.XLEN(XLEN), .OPC_W(OPC_W)) u_mem_align (
      .alucode_i    (bus.in_alucode),
      .is_load_i    (bus.in_is_load),
      .is_store_i   (bus.in_is_store),
      .addr_i       (bus.in_alu_result[1:0]),
      .rdata_i      (bus.in_mem_rdata),
      .rs2_i        (bus.in_rs2),
      .ld_data_o    (ld_data),
      .st_data_o    (bus.st_data),
      .st_be_o      (bus.st_be),
      .misaligned_o (mis_raw)
   );

   assign misaligned = bus.in_valid && mis_raw;

`ifdef WB_STAGE_SKID_EN
   assign in_ready = !skid_vld_q;
`else
   assign in_ready = !out_vld_q || bus.out_ready;
`endif
   assign cap = bus.in_valid && in_ready && !bus.flush;

   // A misaligned load still flows down the pipe but must not write the register file.
   always_comb begin
      pl_new          = '0;
      pl_new.pc_next  = XLEN_DEF'(bus.in_pc_next);
      pl_new.br_taken = bus.in_br_taken;
      pl_new.reg_we   = bus.in_reg_we && !(bus.in_is_load && mis_raw);
      pl_new.rd       = RIDX_W_DEF'(bus.in_rd);
      pl_new.wdata    = XLEN_DEF'(bus.in_is_load ? ld_data : bus.in_alu_result);
   end

   always_comb begin
      out_vld_d = out_vld_q;
      out_d     = out_q;
`ifdef WB_STAGE_SKID_EN
      skid_vld_d = skid_vld_q;
      skid_d     = skid_q;
`endif
      if (bus.flush) begin
         out_vld_d = 1'b0;
`ifdef WB_STAGE_SKID_EN
         skid_vld_d = 1'b0;
`endif
      end else if (cap) begin
`ifdef WB_STAGE_SKID_EN
         if (!out_vld_q || bus.out_ready) begin
            out_vld_d = 1'b1;
            out_d     = pl_new;
         end else begin
            skid_vld_d = 1'b1;
            skid_d     = pl_new;
         end
`else
         out_vld_d = 1'b1;
         out_d     = pl_new;
`endif
      end else if (out_vld_q && bus.out_ready) begin
`ifdef WB_STAGE_SKID_EN
         if (skid_vld_q) begin
            out_d      = skid_q;
            skid_vld_d = 1'b0;
         end else begin
            out_vld_d = 1'b0;
         end
`else
         out_vld_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_vld_q <= 1'b0;
         out_q     <= '0;
`ifdef WB_STAGE_SKID_EN
         skid_vld_q <= 1'b0;
         skid_q     <= '0;
`endif
      end else begin
         out_vld_q <= out_vld_d;
         out_q     <= out_d;
`ifdef WB_STAGE_SKID_EN
         skid_vld_q <= skid_vld_d;
         skid_q     <= skid_d;
`endif
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.st_en        = cap && bus.in_is_store && !misaligned;
   assign bus.misaligned   = misaligned;

   assign bus.out_valid    = out_vld_q;
   assign bus.out_pc_next  = XLEN'(out_q.pc_next);
   assign bus.out_br_taken = out_vld_q && out_q.br_taken;
   assign bus.out_reg_we   = out_vld_q && out_q.reg_we && (out_q.rd != '0);
   assign bus.out_rd       = out_vld_q ? RIDX_W'(out_q.rd) : '0;
   assign bus.out_wdata    = XLEN'(out_q.wdata);

   assign bus.fwd_valid    = bus.out_reg_we;
   assign bus.fwd_rd       = bus.out_rd;
   assign bus.fwd_data     = bus.out_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed vectors push expected results; a negedge
// monitor compares every presented output against the queue head.
module tb_wb_stage;
   import wb_pkg::*;

   typedef struct {
      logic [31:0] pc;
      logic        br, ld, st, we;
      logic [4:0]  rd;
      logic [5:0]  opc;
      logic [31:0] alu, rs2, rdata;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic        br;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wd;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_total = 0;
   int   n_pass  = 0;
   int   br_xfers = 0;
   int   cyc = 0;
   exp_t q[$];

   wb_stage_if #(.XLEN(32), .RIDX_W(5), .OPC_W(6)) bus ();

   wb_stage #(.XLEN(32), .RIDX_W(5), .OPC_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endfunction

   always @(negedge clk) begin
      if (rst && bus.out_valid) begin
         if (q.size() == 0) begin
            chk("out_valid_unexpected", 32'(bus.out_valid), 32'd0);
         end else begin
            chk("out_pc_next",  bus.out_pc_next,         q[0].pc);
            chk("out_br_taken", 32'(bus.out_br_taken),   32'(q[0].br));
            chk("out_reg_we",   32'(bus.out_reg_we),     32'(q[0].we));
            chk("out_rd",       32'(bus.out_rd),         32'(q[0].rd));
            chk("out_wdata",    bus.out_wdata,           q[0].wd);
            chk("fwd_valid",    32'(bus.fwd_valid),      32'(q[0].we));
            chk("fwd_rd",       32'(bus.fwd_rd),         32'(q[0].rd));
            chk("fwd_data",     bus.fwd_data,            q[0].wd);
            if (bus.out_ready) begin
               if (bus.out_br_taken) br_xfers++;
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic drive(input vec_t v);
      bus.in_valid      = 1'b1;
      bus.in_pc_next    = v.pc;
      bus.in_br_taken   = v.br;
      bus.in_is_load    = v.ld;
      bus.in_is_store   = v.st;
      bus.in_reg_we     = v.we;
      bus.in_rd         = v.rd;
      bus.in_alucode    = v.opc;
      bus.in_alu_result = v.alu;
      bus.in_rs2        = v.rs2;
      bus.in_mem_rdata  = v.rdata;
   endtask

   task automatic idle_inputs();
      bus.in_valid = 1'b0; bus.in_pc_next = '0; bus.in_br_taken = 1'b0;
      bus.in_is_load = 1'b0; bus.in_is_store = 1'b0; bus.in_reg_we = 1'b0;
      bus.in_rd = '0; bus.in_alucode = '0; bus.in_alu_result = '0;
      bus.in_rs2 = '0; bus.in_mem_rdata = '0;
   endtask

   task automatic xfer(input exp_t e);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_ready && !bus.flush) begin
            q.push_back(e);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      chk("send_timeout_in_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic send(input vec_t v, input exp_t e);
      drive(v);
      xfer(e);
   endtask

   task automatic chk_store(input string nm, input logic [3:0] be, input logic [31:0] data,
                            input logic en, input logic mis);
      chk({nm, "_st_be"},      32'(bus.st_be),      32'(be));
      chk({nm, "_st_data"},    bus.st_data,         data);
      chk({nm, "_st_en"},      32'(bus.st_en),      32'(en));
      chk({nm, "_misaligned"}, 32'(bus.misaligned), 32'(mis));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      logic exp_stall_rdy;
      vec_t v;
      rst = 1'b0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      idle_inputs();
      #2;
      chk("rst_out_valid",  32'(bus.out_valid),    32'd0);
      chk("rst_in_ready",   32'(bus.in_ready),     32'd1);
      chk("rst_out_reg_we", 32'(bus.out_reg_we),   32'd0);
      chk("rst_out_rd",     32'(bus.out_rd),       32'd0);
      chk("rst_out_br",     32'(bus.out_br_taken), 32'd0);
      chk("rst_out_wdata",  bus.out_wdata,         32'd0);
      chk("rst_fwd_valid",  32'(bus.fwd_valid),    32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;

      // LW aligned, then one-cycle latency
      v = '{32'h104, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, OPC_LW, 32'h100, 32'h0, 32'hDEADBEEF};
      drive(v); #1;
      chk_store("lw", 4'b0000, 32'h0, 1'b0, 1'b0);
      xfer('{32'h104, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF});
      @(negedge clk);
      chk("lw_latency_out_valid", 32'(bus.out_valid), 32'd1);
      chk("lw_fwd_rd", 32'(bus.fwd_rd), 32'd5);
      @(posedge clk); #1;

      // back-to-back loads: one capture per cycle
      c0 = cyc;
      send('{32'h108, 1'b0, 1'b1, 1'b0, 1'b1, 5'd6, OPC_LB,  32'h103, 32'h0, 32'h80123456},
           '{32'h108, 1'b0, 1'b1, 5'd6, 32'hFFFFFF80});
      send('{32'h10C, 1'b0, 1'b1, 1'b0, 1'b1, 5'd6, OPC_LBU, 32'h103, 32'h0, 32'h80123456},
           '{32'h10C, 1'b0, 1'b1, 5'd6, 32'h00000080});
      send('{32'h110, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, OPC_LH,  32'h102, 32'h0, 32'h80123456},
           '{32'h110, 1'b0, 1'b1, 5'd8, 32'hFFFF8012});
      send('{32'h114, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, OPC_LHU, 32'h100, 32'h0, 32'h80123456},
           '{32'h114, 1'b0, 1'b1, 5'd9, 32'h00003456});
      chk("throughput_cycles", 32'(cyc - c0), 32'd4);

      // stores
      drive('{32'h118, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, OPC_SH, 32'h102, 32'h0000ABCD, 32'h0}); #1;
      chk_store("sh", 4'b1100, 32'hABCDABCD, 1'b1, 1'b0);
      xfer('{32'h118, 1'b0, 1'b0, 5'd0, 32'h102});
      drive('{32'h11C, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, OPC_SB, 32'h101, 32'h12345678, 32'h0}); #1;
      chk_store("sb", 4'b0010, 32'h78787878, 1'b1, 1'b0);
      xfer('{32'h11C, 1'b0, 1'b0, 5'd0, 32'h101});
      drive('{32'h120, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, OPC_SW, 32'h102, 32'hCAFEF00D, 32'h0}); #1;
      chk_store("sw_mis", 4'b1111, 32'hCAFEF00D, 1'b0, 1'b1);
      xfer('{32'h120, 1'b0, 1'b0, 5'd0, 32'h102});

      // misaligned load captured without register write; rd=0 suppresses write
      drive('{32'h124, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, OPC_LW, 32'h101, 32'h0, 32'h11223344}); #1;
      chk_store("lw_mis", 4'b0000, 32'h0, 1'b0, 1'b1);
      xfer('{32'h124, 1'b0, 1'b0, 5'd7, 32'h11223344});
      send('{32'h128, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 6'h00, 32'h12345678, 32'h0, 32'h0},
           '{32'h128, 1'b0, 1'b0, 5'd0, 32'h12345678});
      @(negedge clk);

      // taken branch stalled for 3 cycles
`ifdef WB_STAGE_SKID_EN
      exp_stall_rdy = 1'b1;
`else
      exp_stall_rdy = 1'b0;
`endif
      @(posedge clk); #1;
      br_xfers = 0;
      bus.out_ready = 1'b0;
      send('{32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'h00, 32'h55, 32'h0, 32'h0},
           '{32'h200, 1'b1, 1'b0, 5'd0, 32'h55});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_br_taken", 32'(bus.out_br_taken), 32'd1);
         chk("stall_in_ready", 32'(bus.in_ready), 32'(exp_stall_rdy));
      end
      @(posedge clk); #1 bus.out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("br_after_valid", 32'(bus.out_valid), 32'd0);
      chk("br_after_taken", 32'(bus.out_br_taken), 32'd0);
      chk("br_after_rd",    32'(bus.out_rd), 32'd0);
      chk("br_xfers",       32'(br_xfers), 32'd1);

      // flush kills held entry and blocks capture
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      send('{32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 6'h00, 32'hA5A5, 32'h0, 32'h0},
           '{32'h300, 1'b0, 1'b1, 5'd10, 32'hA5A5});
      drive('{32'h304, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, OPC_SW, 32'h100, 32'h1, 32'h0});
      bus.flush = 1'b1; #1;
      chk("flush_st_en", 32'(bus.st_en), 32'd0);
      @(posedge clk); #1;
      q.delete();
      bus.flush = 1'b0;
      idle_inputs();
      @(negedge clk);
      chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
      chk("flush_fwd_valid", 32'(bus.fwd_valid), 32'd0);
      chk("flush_in_ready",  32'(bus.in_ready),  32'd1);

      // reset while stalled
      @(posedge clk); #1;
      send('{32'h400, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 6'h00, 32'h77, 32'h0, 32'h0},
           '{32'h400, 1'b1, 1'b1, 5'd4, 32'h77});
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      idle_inputs();
      #1;
      chk("rstmid_out_valid", 32'(bus.out_valid),    32'd0);
      chk("rstmid_out_br",    32'(bus.out_br_taken), 32'd0);
      chk("rstmid_out_we",    32'(bus.out_reg_we),   32'd0);
      chk("rstmid_out_rd",    32'(bus.out_rd),       32'd0);
      chk("rstmid_out_wdata", bus.out_wdata,         32'd0);
      chk("rstmid_out_pc",    bus.out_pc_next,       32'd0);
      chk("rstmid_fwd_data",  bus.fwd_data,          32'd0);
      chk("rstmid_st_en",     32'(bus.st_en),        32'd0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("rstrel_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rstrel_out_valid", 32'(bus.out_valid), 32'd0);

      // two inputs during a stall are delivered in order
      @(posedge clk); #1;
      fork
         begin
            send('{32'h500, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 6'h00, 32'hD, 32'h0, 32'h0},
                 '{32'h500, 1'b0, 1'b1, 5'd11, 32'hD});
            send('{32'h504, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 6'h00, 32'hE, 32'h0, 32'h0},
                 '{32'h504, 1'b0, 1'b1, 5'd12, 32'hE});
`ifdef WB_STAGE_SKID_EN
            @(negedge clk);
            chk("skid_full_in_ready", 32'(bus.in_ready), 32'd0);
`endif
         end
         begin
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter RIDX_W, default 5, register index width.
REQ-003 SHALL have parameter OPC_W, default 6, alucode width.
REQ-004 SHALL have port clk  in  1  single clock, all state on posedge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports in_valid in 1, in_ready out 1: upstream handshake.
REQ-007 SHALL have ports in_pc_next in XLEN, in_br_taken in 1, in_is_load in 1, in_is_store in 1, in_reg_we in 1, in_rd in RIDX_W, in_alucode in OPC_W, in_alu_result in XLEN, in_rs2 in XLEN, in_mem_rdata in XLEN: stage payload.
REQ-008 SHALL have port flush  in  1  kill the held entry and block capture this cycle.
REQ-009 SHALL have ports out_valid out 1, out_ready in 1: downstream handshake.
REQ-010 SHALL have ports out_pc_next out XLEN, out_br_taken out 1, out_reg_we out 1, out_rd out RIDX_W, out_wdata out XLEN: writeback result.
REQ-011 SHALL have ports st_data out XLEN, st_be out 4, st_en out 1, misaligned out 1: store path and alignment fault.
REQ-012 SHALL have ports fwd_valid out 1, fwd_rd out RIDX_W, fwd_data out XLEN: bypass to decode.

Function
REQ-013 SHALL capture the payload on posedge clk when in_valid && in_ready && !flush.
REQ-014 SHALL drive in_ready = !out_valid || out_ready (combinational form; see REQ-029).
REQ-015 SHALL set out_valid on capture; clear it on out_valid && out_ready with no new capture; clear it on flush regardless of out_ready.
REQ-016 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-017 SHALL gate out_reg_we = out_valid && held reg_we && held rd != 0.
REQ-018 SHALL gate out_rd to 0 and out_br_taken to 0 when out_valid is 0.
REQ-019 SHALL assert out_br_taken for exactly one accepted transfer per captured taken branch; never repeat while stalled-then-accepted.
REQ-020 SHALL compute out_wdata for loads from in_mem_rdata by alucode: LB/LH sign-extend, LBU/LHU zero-extend, LW pass; byte/half lane chosen by alu_result[1:0]; non-loads pass alu_result.
REQ-021 SHALL compute st_be: SB 0001<<addr[1:0], SH 0011<<{addr[1],0}, SW 1111; st_data = rs2 byte/half replicated across lanes; st_en = in_valid && in_ready && in_is_store && !flush && !misaligned.
REQ-022 SHALL assert misaligned (combinational, capture cycle) for half access with addr[0]=1 or word access with addr[1:0]!=0; a misaligned load SHALL capture with reg_we forced 0.
REQ-023 SHALL drive fwd_valid = out_reg_we, fwd_rd = out_rd, fwd_data = out_wdata.
REQ-024 SHALL give flush priority over simultaneous capture and transfer; out_valid=0 next cycle.
REQ-025 SHALL have latency 1 cycle input-to-output when not stalled; full throughput (one per cycle).

Reset
REQ-026 SHALL on rst low clear out_valid, out_br_taken, held reg_we, held rd, st_en-related state, skid state; data registers SHALL be 0.
REQ-027 SHALL discard any held or skidded entry on reset mid-stall; in_ready SHALL be 1 after reset release.

Configuration
REQ-028 SHALL compile a one-entry skid buffer when WB_STAGE_SKID_EN is defined.
REQ-029 SHALL with WB_STAGE_SKID_EN drive in_ready from a flop (= skid empty); a capture while stalled goes to skid, drains to output on next out_ready; flush empties both; without the macro REQ-014 applies.

Structure
REQ-030 SHALL place load/store alucode constants, XLEN default and a wb_payload_t packed struct in package wb_pkg.
REQ-031 SHALL implement lane extraction/replication in sub-module mem_align (combinational), instantiated once.

Verification
REQ-032 LW addr 0x100, mem_rdata 0xDEADBEEF, rd=5, out_ready=1 -> next cycle out_wdata 0xDEADBEEF, out_reg_we 1, fwd_rd 5.
REQ-033 LB addr 0x103, mem_rdata 0x80123456 -> out_wdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-034 SH addr 0x102, rs2 0x0000ABCD -> st_be 1100, st_data 0xABCDABCD, st_en 1; SW addr 0x102 -> misaligned 1, st_en 0.
REQ-035 Taken branch captured, out_ready=0 for 3 cycles then 1 -> out_br_taken high only while out_valid, single transfer counted; rd=0 with reg_we=1 -> out_reg_we 0.
REQ-036 flush with in_valid=1 and held entry -> out_valid 0 next cycle, no capture; rst low mid-stall -> all outputs 0, in_ready 1 after release; with WB_STAGE_SKID_EN, back-to-back 2 inputs during stall -> both delivered in order.
